// File: rtl/fft_8p_frame_buf.sv
// Purpose: ping-pong serial-to-parallel frame buffer feeding the 8-point FFT; optional FFT_FRAME_BUF_PRESCALE_EN stores samples pre-shifted by log2(N).
// Latency: a frame is presented on x_real/x_imag the cycle after its N-th sample is accepted, with no extra register stage.
// Backpressure: s_ready drops while the write bank is full (both banks held); each frame is held until o_valid && o_ready.
module fft_8p_frame_buf #(
    parameter int DATA_WIDTH = 16,
    parameter int N          = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic signed [DATA_WIDTH-1:0] s_real,
    input  logic signed [DATA_WIDTH-1:0] s_imag,
    input  logic                         s_last,
    output logic signed [DATA_WIDTH-1:0] x_real [N],
    output logic signed [DATA_WIDTH-1:0] x_imag [N],
    output logic                         o_valid,
    input  logic                         o_ready,
    output logic                         frame_err
);

    localparam int               CNT_W    = $clog2(N);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);

    logic signed [DATA_WIDTH-1:0] bank_re [2][N];
    logic signed [DATA_WIDTH-1:0] bank_im [2][N];
    logic [1:0]                   bank_full;
    logic                         wr_bank;
    logic                         rd_bank;
    logic [CNT_W-1:0]             wr_cnt;

    logic                         accept;
    logic                         complete;
    logic                         malformed;
    logic                         rel_frm;
    logic signed [DATA_WIDTH-1:0] st_re;
    logic signed [DATA_WIDTH-1:0] st_im;

    assign s_ready   = !rst && !bank_full[wr_bank];
    assign accept    = s_valid && s_ready;
    assign complete  = accept && (wr_cnt == LAST_IDX);
    assign malformed = accept && s_last && (wr_cnt != LAST_IDX);
    assign o_valid   = bank_full[rd_bank];
    assign rel_frm   = o_valid && o_ready;

    // Arithmetic shift keeps the worst-case FFT gain of N inside DATA_WIDTH.
    always_comb begin
        st_re = s_real;
        st_im = s_imag;
`ifdef FFT_FRAME_BUF_PRESCALE_EN
        st_re = s_real >>> CNT_W;
        st_im = s_imag >>> CNT_W;
`else
`endif
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            x_real[i] = bank_re[rd_bank][i];
            x_imag[i] = bank_im[rd_bank][i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < N; i++) begin
                    bank_re[b][i] <= '0;
                    bank_im[b][i] <= '0;
                end
            end
            bank_full <= '0;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= malformed;

            if (accept) begin
                bank_re[wr_bank][wr_cnt] <= st_re;
                bank_im[wr_bank][wr_cnt] <= st_im;
            end

            if (complete) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
            end else if (malformed) begin
                wr_cnt <= '0;
            end else if (accept) begin
                wr_cnt <= wr_cnt + 1'b1;
            end

            // Release and completion never collide on one bank: a bank being
            // released is full, a bank being completed is still empty.
            if (rel_frm) begin
                bank_full[rd_bank] <= 1'b0;
                rd_bank            <= ~rd_bank;
            end
            if (complete) begin
                bank_full[wr_bank] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fft_8p_frame_buf.sv
// Directed bench for fft_8p_frame_buf; a queue scoreboard holds expected frames pushed on acceptance and popped on release.
module tb_fft_8p_frame_buf;

    localparam int DW = 16;
    localparam int N  = 8;

    logic                 clk;
    logic                 rst;
    logic                 s_valid;
    logic                 s_ready;
    logic signed [DW-1:0] s_real;
    logic signed [DW-1:0] s_imag;
    logic                 s_last;
    logic signed [DW-1:0] x_real [N];
    logic signed [DW-1:0] x_imag [N];
    logic                 o_valid;
    logic                 o_ready;
    logic                 frame_err;

    fft_8p_frame_buf #(.DATA_WIDTH(DW), .N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_real    (s_real),
        .s_imag    (s_imag),
        .s_last    (s_last),
        .x_real    (x_real),
        .x_imag    (x_imag),
        .o_valid   (o_valid),
        .o_ready   (o_ready),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic signed [DW-1:0] part_re [$];
    logic signed [DW-1:0] part_im [$];
    logic signed [DW-1:0] exp_re  [$];
    logic signed [DW-1:0] exp_im  [$];
    bit                   exp_err = 1'b0;
    int                   frames_seen = 0;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    endtask

    function automatic logic signed [DW-1:0] scale(input int v);
        logic signed [DW-1:0] t;
        t = DW'(v);
`ifdef FFT_FRAME_BUF_PRESCALE_EN
        t = t >>> $clog2(N);
`endif
        return t;
    endfunction

    function automatic int held();
        return exp_re.size() / N;
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic cyc(input bit v, input int re, input int im, input bit last, input bit ordy, output bit acc);
        bit model_rdy;
        s_valid = v;
        s_real  = DW'(re);
        s_imag  = DW'(im);
        s_last  = last;
        o_ready = ordy;
        #1;
        model_rdy = (held() < 2);
        chk("s_ready", 32'(s_ready), 32'(model_rdy));
        chk("o_valid", 32'(o_valid), 32'(held() > 0));
        chk("frame_err", 32'(frame_err), 32'(exp_err));
        if (held() > 0 && ordy) begin
            for (int k = 0; k < N; k++) begin
                chk($sformatf("x_real[%0d] frame%0d", k, frames_seen), x_real[k], exp_re[k]);
                chk($sformatf("x_imag[%0d] frame%0d", k, frames_seen), x_imag[k], exp_im[k]);
            end
            for (int k = 0; k < N; k++) begin
                void'(exp_re.pop_front());
                void'(exp_im.pop_front());
            end
            frames_seen++;
        end
        exp_err = 1'b0;
        acc = v && model_rdy;
        if (acc) begin
            part_re.push_back(scale(re));
            part_im.push_back(scale(im));
            if (part_re.size() == N) begin
                for (int k = 0; k < N; k++) begin
                    exp_re.push_back(part_re[k]);
                    exp_im.push_back(part_im[k]);
                end
                part_re.delete();
                part_im.delete();
            end else if (last) begin
                part_re.delete();
                part_im.delete();
                exp_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    // Sends samples start..start+cnt-1 (imag negated), holding each until accepted.
    task automatic send(input int start, input int cnt, input int last_at, input bit ordy);
        bit acc;
        int sent  = 0;
        int guard = 0;
        while (sent < cnt && guard < 200) begin
            cyc(1'b1, start + sent, -(start + sent), (sent == last_at), ordy, acc);
            if (acc) sent++;
            guard++;
        end
        chk("send_done", sent, cnt);
    endtask

    task automatic idle(input int cycles, input bit ordy);
        bit acc;
        for (int i = 0; i < cycles; i++) cyc(1'b0, 0, 0, 1'b0, ordy, acc);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        o_ready = 1'b0;
        s_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 0);
        chk("rst_o_valid", 32'(o_valid), 0);
        rst = 1'b0;
        part_re.delete();
        part_im.delete();
        exp_re.delete();
        exp_im.delete();
        exp_err = 1'b0;
        #1;
        chk("post_rst_s_ready", 32'(s_ready), 1);
        chk("post_rst_frame_err", 32'(frame_err), 0);
        for (int k = 0; k < N; k++) begin
            chk($sformatf("post_rst_x_real[%0d]", k), x_real[k], 0);
            chk($sformatf("post_rst_x_imag[%0d]", k), x_imag[k], 0);
        end
    endtask

    initial begin
        bit acc;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_real  = '0;
        s_imag  = '0;
        s_last  = 1'b0;
        o_ready = 1'b0;
        @(negedge clk);
        do_reset();

        // Single frame 1..8 with the consumer always ready.
        send(1, 8, -1, 1'b1);
        idle(3, 1'b1);
        chk("t1_frames", frames_seen, 1);

        // Consumer stalled: two frames fill both banks, the third waits.
        send(9, 16, -1, 1'b0);
        idle(3, 1'b0);
        chk("t2_both_full_ready", 32'(s_ready), 0);
        cyc(1'b1, 25, -25, 1'b0, 1'b1, acc);
        chk("t2_release_cycle_stall", 32'(acc), 0);
        send(25, 8, -1, 1'b0);
        idle(4, 1'b1);
        chk("t2_frames", frames_seen, 4);

        // Early s_last on the third sample discards that partial frame.
        send(40, 3, 2, 1'b1);
        send(50, 8, -1, 1'b1);
        idle(3, 1'b1);
        chk("t3_frames", frames_seen, 5);

        // Four back-to-back frames with no input stalls.
        for (int i = 0; i < 4 * N; i++) begin
            cyc(1'b1, 100 + i, -(100 + i), 1'b0, 1'b1, acc);
            chk("t4_no_stall", 32'(acc), 1);
        end
        idle(3, 1'b1);
        chk("t4_frames", frames_seen, 9);

        // Reset mid-frame while another frame is held.
        send(200, 8, -1, 1'b0);
        send(300, 5, -1, 1'b0);
        do_reset();
        chk("t5_o_valid", 32'(o_valid), 0);
        idle(1, 1'b0);
        send(400, 8, -1, 1'b1);
        idle(3, 1'b1);
        chk("t5_frames", frames_seen, 10);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
